// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FIFO (FWFT) with status, sticky overflow and level IRQ
// Optional idle-timeout interrupt: define UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DEPTH_LOG2   = 4,
  parameter int CLKS_PER_BIT = 50,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                  i_Clock,
  input  logic                  reset_n,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  input  logic                  i_rd,
  input  logic                  i_flush,
  input  logic                  i_clr_ovf,
  input  logic [DEPTH_LOG2:0]   i_thresh,
  output logic [7:0]            o_rd_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_timeout,
  output logic                  o_irq
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;

  logic empty, full, push_ok, pop_ok, ovf_set, thr_hit, timeout;

  // Full/empty come only from the count, so pointer equality never needs disambiguating.
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_ok  = i_rd && !empty && !i_flush;
  assign push_ok = i_Rx_DV && !i_flush && (!full || pop_ok);
  assign ovf_set = i_Rx_DV && !i_flush && full && !pop_ok;
  assign thr_hit = (i_thresh != '0) && (count_q >= i_thresh);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_d    = thr_hit | timeout;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
      else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end
    // A new overflow in the same cycle as a clear keeps the flag set.
    if (ovf_set)        ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_Rx_Byte;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic [1:0] {T_OFF, T_COUNT, T_FIRED} to_state_e;

  to_state_e       to_state_q, to_state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            activity;

  assign activity = i_Rx_DV | pop_ok;

  always_comb begin
    to_state_d = to_state_q;
    to_cnt_d   = to_cnt_q;
    if (i_flush || empty) begin
      to_state_d = T_OFF;
      to_cnt_d   = '0;
    end else begin
      unique case (to_state_q)
        T_OFF: begin
          to_state_d = T_COUNT;
          to_cnt_d   = '0;
        end
        T_COUNT: begin
          if (activity)                  to_cnt_d   = '0;
          else if (to_cnt_q == TO_LAST)  to_state_d = T_FIRED;
          else                           to_cnt_d   = to_cnt_q + TO_ONE;
        end
        T_FIRED: begin
          if (activity) begin
            to_state_d = T_COUNT;
            to_cnt_d   = '0;
          end
        end
        default: to_state_d = T_OFF;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      to_state_q <= T_OFF;
      to_cnt_q   <= '0;
    end else begin
      to_state_q <= to_state_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign timeout = (to_state_q == T_FIRED);
`else
  assign timeout = 1'b0;
`endif

  assign o_rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_overflow = ovf_q;
  assign o_timeout  = timeout;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized + directed bench for uart_rx_ctrl against a queue model
module tb_uart_rx_ctrl;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dv = 1'b0, rd = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [DL:0]   thresh = '0;
  logic [7:0]    rd_data;
  logic [DL:0]   count;
  logic          empty, full, ovf, tmo, irq;

  logic [7:0]    mq[$];
  logic          m_ovf = 1'b0;
  logic          m_irq = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  uart_rx_ctrl #(.DEPTH_LOG2(DL), .CLKS_PER_BIT(50), .TIMEOUT_BITS(40)) dut (
    .i_Clock(clk), .reset_n(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte), .i_rd(rd),
    .i_flush(flush), .i_clr_ovf(clr), .i_thresh(thresh), .o_rd_data(rd_data),
    .o_count(count), .o_empty(empty), .o_full(full), .o_overflow(ovf),
    .o_timeout(tmo), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_irq = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, return at the next negedge.
  task automatic tick(input logic d, input logic [7:0] b, input logic r, input logic f, input logic c);
    int  sz;
    logic pop, newovf;
    dv = d; rx_byte = b; rd = r; flush = f; clr = c;
    @(posedge clk);
    sz     = mq.size();
    newovf = 1'b0;
    m_irq  = (thresh != 0) && (sz >= int'(thresh));
    if (f) mq.delete();
    else begin
      pop = r && (sz > 0);
      if (pop) void'(mq.pop_front());
      if (d) begin
        if (sz == DEPTH && !pop) newovf = 1'b1;
        else mq.push_back(b);
      end
    end
    if (newovf) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(negedge clk);
    dv = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("rd_data", 32'(rd_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("timeout", 32'(tmo), 32'h0);
  endtask

  task automatic step(input logic d, input logic [7:0] b, input logic r, input logic f, input logic c);
    tick(d, b, r, f, c);
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf), 32'h0);
    chk({tag, "_tmo"}, 32'(tmo), 32'h0);
    chk({tag, "_irq"}, 32'(irq), 32'h0);
    chk({tag, "_data"}, 32'(rd_data), 32'h0);
  endtask

  initial begin
    int fired;
    int p_dv, p_rd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // Single byte in and out
    step(1, 8'hA5, 0, 0, 0);
    chk("t1_data", 32'(rd_data), 32'hA5);
    chk("t1_count", 32'(count), 32'h1);
    step(0, 0, 1, 0, 0);
    chk("t1_empty", 32'(empty), 32'h1);
    step(0, 0, 1, 0, 0);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    chk("t2_full", 32'(full), 32'h1);
    step(1, 8'h55, 0, 0, 0);
    chk("t2_ovf", 32'(ovf), 32'h1);
    chk("t2_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", 32'(rd_data), 32'(i));
      step(0, 0, 1, 0, 0);
    end
    chk("t2_drained", 32'(empty), 32'h1);

    // Full + simultaneous push/pop, then clear colliding with a new overflow
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_noovf", 32'(ovf), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0, 0);
    chk("t3_last", 32'(rd_data), 32'h77);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 1);
    chk("t3_clr_vs_ovf", 32'(ovf), 32'h1);
    step(0, 0, 0, 1, 1);
    chk("t3_flush", 32'(count), 32'h0);

    // Threshold interrupt
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_below", 32'(irq), 32'h0);
    step(1, 8'h33, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_at", 32'(irq), 32'h1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_drop", 32'(irq), 32'h0);
    thresh = 5'd0;
    for (int i = 0; i < 13; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_disabled", 32'(irq), 32'h0);
    thresh = 5'd17;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_above_depth", 32'(irq), 32'h0);
    thresh = 5'd16;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4_at_depth", 32'(irq), 32'h1);
    step(0, 0, 0, 1, 0);

    // Randomized traffic in segments with varied fill pressure
    for (int seg = 0; seg < 8; seg++) begin
      p_dv = $urandom_range(20, 90);
      p_rd = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 3) thresh = 5'($urandom_range(0, 20));
        step($urandom_range(0, 99) < p_dv, 8'($urandom), $urandom_range(0, 99) < p_rd,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
      end
    end

    // Reset mid-stream with a push in flight
    step(0, 0, 0, 1, 1);
    thresh = 5'd2;
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    dv = 1'b1; rx_byte = 8'h99;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5");
    @(posedge clk);
    @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b1;
    model_reset();
    thresh = 5'd0;
    step(1, 8'h3C, 0, 0, 0);
    chk("t5_data", 32'(rd_data), 32'h3C);
    chk("t5_count", 32'(count), 32'h1);

    // Idle timeout
    step(0, 0, 0, 1, 1);
    tick(1, 8'hE1, 0, 0, 0);
    fired = -1;
    for (int k = 1; k <= 2300 && fired < 0; k++) begin
      tick(0, 0, 0, 0, 0);
      if (tmo) fired = k;
    end
`ifdef UART_RX_TIMEOUT_EN
    chk("t6_fire_window", 32'(fired >= 1950 && fired <= 2050), 32'h1);
    tick(0, 0, 0, 0, 0);
    chk("t6_irq", 32'(irq), 32'h1);
    tick(0, 0, 1, 0, 0);
    chk("t6_tmo_clr", 32'(tmo), 32'h0);
    tick(0, 0, 0, 0, 0);
    chk("t6_irq_clr", 32'(irq), 32'h0);
    tick(1, 8'hB1, 0, 0, 0);
    fired = -1;
    for (int k = 1; k < 1000 && fired < 0; k++) begin
      tick(0, 0, 0, 0, 0);
      if (tmo) fired = k;
    end
    chk("t6_no_early", 32'(fired), 32'hFFFF_FFFF);
    tick(1, 8'hB2, 0, 0, 0);
    for (int k = 1; k <= 2300 && fired < 0; k++) begin
      tick(0, 0, 0, 0, 0);
      if (tmo) fired = k;
    end
    chk("t6_restart_window", 32'(fired >= 1950 && fired <= 2050), 32'h1);
`else
    chk("t6_never_fires", 32'(fired), 32'hFFFF_FFFF);
    chk("t6_irq_off", 32'(irq), 32'h0);
`endif
    step(0, 0, 0, 1, 0);
    chk("t6_end_empty", 32'(empty), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
